// File: rtl/write_back_unit.sv
// Register write-back initiator: ALU and LSU results are queued per source, then
// one write-back per cycle is issued in round-robin order.
// Optional build macro WRITE_BACK_BYPASS_EN adds a one-cycle ALU path when both queues are idle.

// Generic single-clock FIFO.
// Latency: a pushed entry is visible at the head one edge after the push.
// Backpressure: full depends on registered occupancy only; a push while full is ignored.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_vld & ~empty;
    assign head_dat = mem[rd_ptr];

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// Write-back arbiter: two source FIFOs, round-robin pop, registered strobe/index/result.
// Latency: accept at edge k, strobe between edges k+1 and k+2 (edge k to k+1 on the bypass path).
// Backpressure: per-source ready is "queue not full" from registered state; no pop pass-through.
module write_back_unit #(
    parameter int QUEUE_DEPTH               = 4,
    parameter int REGISTER_DESCRIPTOR_WIDTH = 5,
    parameter int OPERAND_WIDTH             = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 alu_valid_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] alu_register_input,
    input  logic [OPERAND_WIDTH-1:0]             alu_result_input,
    output logic                                 alu_ready_output,
    input  logic                                 lsu_valid_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] lsu_register_input,
    input  logic [OPERAND_WIDTH-1:0]             lsu_result_input,
    output logic                                 lsu_ready_output,
    output logic                                 write_back_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] write_back_register_output,
    output logic [OPERAND_WIDTH-1:0]             result_output
);
    typedef struct packed {
        logic [REGISTER_DESCRIPTOR_WIDTH-1:0] dst;
        logic [OPERAND_WIDTH-1:0]             res;
    } wb_entry_t;

    localparam int   EW     = $bits(wb_entry_t);
    localparam logic RR_ALU = 1'b0;
    localparam logic RR_LSU = 1'b1;

    wb_entry_t alu_in_dat, lsu_in_dat, alu_head_dat, lsu_head_dat, pop_dat;
    logic      alu_full, alu_empty, lsu_full, lsu_empty;
    logic      alu_push_vld, lsu_push_vld, alu_pop_vld, lsu_pop_vld;
    logic      bypass_vld, pop_vld;
    logic      rr_ptr;

    assign alu_in_dat       = '{dst: alu_register_input, res: alu_result_input};
    assign lsu_in_dat       = '{dst: lsu_register_input, res: lsu_result_input};
    assign alu_ready_output = ~alu_full;
    assign lsu_ready_output = ~lsu_full;
    assign alu_push_vld     = alu_valid_input & ~alu_full;
    assign lsu_push_vld     = lsu_valid_input & ~lsu_full;

`ifdef WRITE_BACK_BYPASS_EN
    assign bypass_vld = alu_push_vld & alu_empty & lsu_empty & ~lsu_valid_input;
`else
    assign bypass_vld = 1'b0;
`endif

    // A lone non-empty queue always wins; the pointer only breaks ties.
    assign alu_pop_vld = ~alu_empty & (lsu_empty | (rr_ptr == RR_ALU));
    assign lsu_pop_vld = ~lsu_empty & (alu_empty | (rr_ptr == RR_LSU));
    assign pop_vld     = alu_pop_vld | lsu_pop_vld | bypass_vld;
    assign pop_dat     = bypass_vld  ? alu_in_dat   :
                         alu_pop_vld ? alu_head_dat : lsu_head_dat;

    wb_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(EW)) u_alu_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (alu_push_vld & ~bypass_vld),
        .push_dat (alu_in_dat),
        .pop_vld  (alu_pop_vld),
        .head_dat (alu_head_dat),
        .full     (alu_full),
        .empty    (alu_empty)
    );

    wb_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(EW)) u_lsu_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (lsu_push_vld),
        .push_dat (lsu_in_dat),
        .pop_vld  (lsu_pop_vld),
        .head_dat (lsu_head_dat),
        .full     (lsu_full),
        .empty    (lsu_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= RR_ALU;
        end else if (!alu_empty && !lsu_empty) begin
            rr_ptr <= (rr_ptr == RR_ALU) ? RR_LSU : RR_ALU;
        end
    end

    // Register 0 is never written: such entries drain silently and the outputs hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_back_output          <= 1'b0;
            write_back_register_output <= '0;
            result_output              <= '0;
        end else begin
            write_back_output <= 1'b0;
            if (pop_vld && (pop_dat.dst != '0)) begin
                write_back_output          <= 1'b1;
                write_back_register_output <= pop_dat.dst;
                result_output              <= pop_dat.res;
            end
        end
    end
endmodule

// File: tb/tb_write_back_unit.sv
// Randomized and directed stimulus for write_back_unit, checked against a queue-based reference model.
module tb_write_back_unit;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid_input = 1'b0;
    logic [4:0]  alu_register_input = '0;
    logic [31:0] alu_result_input = '0;
    logic        alu_ready_output;
    logic        lsu_valid_input = 1'b0;
    logic [4:0]  lsu_register_input = '0;
    logic [31:0] lsu_result_input = '0;
    logic        lsu_ready_output;
    logic        write_back_output;
    logic [4:0]  write_back_register_output;
    logic [31:0] result_output;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] v;
    } ent_t;

    ent_t        alu_q[$];
    ent_t        lsu_q[$];
    bit          turn_lsu;
    logic        exp_wb;
    logic [4:0]  exp_reg;
    logic [31:0] exp_res;

    always #5 clk = ~clk;

    write_back_unit #(.QUEUE_DEPTH(D), .REGISTER_DESCRIPTOR_WIDTH(5), .OPERAND_WIDTH(32)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .alu_valid_input            (alu_valid_input),
        .alu_register_input         (alu_register_input),
        .alu_result_input           (alu_result_input),
        .alu_ready_output           (alu_ready_output),
        .lsu_valid_input            (lsu_valid_input),
        .lsu_register_input         (lsu_register_input),
        .lsu_result_input           (lsu_result_input),
        .lsu_ready_output           (lsu_ready_output),
        .write_back_output          (write_back_output),
        .write_back_register_output (write_back_register_output),
        .result_output              (result_output)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        alu_q.delete();
        lsu_q.delete();
        turn_lsu = 1'b0;
        exp_wb   = 1'b0;
        exp_reg  = '0;
        exp_res  = '0;
    endtask

    task automatic check_outputs(input string where);
        check({where, " wb"},      64'(write_back_output),          64'(exp_wb));
        check({where, " reg"},     64'(write_back_register_output), 64'(exp_reg));
        check({where, " res"},     64'(result_output),              64'(exp_res));
        check({where, " alu_rdy"}, 64'(alu_ready_output),           64'(alu_q.size() < D));
        check({where, " lsu_rdy"}, 64'(lsu_ready_output),           64'(lsu_q.size() < D));
    endtask

    // Applies the rules at one rising edge, using the inputs that were stable across it.
    task automatic model_step();
        bit   a_acc, l_acc, bypass, have;
        ent_t got;
        a_acc  = alu_valid_input && (alu_q.size() < D);
        l_acc  = lsu_valid_input && (lsu_q.size() < D);
        have   = 1'b0;
        got    = '{r: '0, v: '0};
        bypass = 1'b0;
`ifdef WRITE_BACK_BYPASS_EN
        bypass = a_acc && alu_q.size() == 0 && lsu_q.size() == 0 && !lsu_valid_input;
`endif
        if (alu_q.size() > 0 && lsu_q.size() > 0) begin
            got      = turn_lsu ? lsu_q.pop_front() : alu_q.pop_front();
            turn_lsu = !turn_lsu;
            have     = 1'b1;
        end else if (alu_q.size() > 0) begin
            got  = alu_q.pop_front();
            have = 1'b1;
        end else if (lsu_q.size() > 0) begin
            got  = lsu_q.pop_front();
            have = 1'b1;
        end
        if (bypass) begin
            got  = '{r: alu_register_input, v: alu_result_input};
            have = 1'b1;
        end else if (a_acc) begin
            alu_q.push_back('{r: alu_register_input, v: alu_result_input});
        end
        if (l_acc) lsu_q.push_back('{r: lsu_register_input, v: lsu_result_input});
        exp_wb = 1'b0;
        if (have && got.r != 0) begin
            exp_wb  = 1'b1;
            exp_reg = got.r;
            exp_res = got.v;
        end
    endtask

    // Called at a falling edge: check, drive, run one rising edge, return at the next falling edge.
    task automatic cycle(input string tag,
                         input logic av, input logic [4:0] ar, input logic [31:0] ares,
                         input logic lv, input logic [4:0] lr, input logic [31:0] lres);
        check_outputs(tag);
        alu_valid_input    = av;
        alu_register_input = ar;
        alu_result_input   = ares;
        lsu_valid_input    = lv;
        lsu_register_input = lr;
        lsu_result_input   = lres;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("in_reset");
        rst = 1'b1;
        idle("post_reset", 2);

        // Single ALU write-back.
        cycle("alu_single", 1'b1, 5'd1, 32'hABCDABCD, 1'b0, 5'd0, 32'd0);
        idle("alu_single_drain", 3);

        // Simultaneous pair, then a repeated pair that goes LSU first.
        cycle("pair1", 1'b1, 5'd2, 32'hBCDEBCDE, 1'b1, 5'd3, 32'hCDEFCDEF);
        cycle("pair1b", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle("pair2", 1'b1, 5'd2, 32'h22222222, 1'b1, 5'd3, 32'h33333333);
        cycle("pair2b", 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd5, 32'h55555555);
        idle("pair_drain", 5);

        // Register 0 is consumed silently.
        cycle("reg0", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        idle("reg0_drain", 3);

        // LSU fills while the ALU contends every cycle.
        for (int i = 0; i < 12; i++)
            cycle("lsu_fill", 1'b1, 5'(8 + i), 32'hA000_0000 + 32'(i),
                  1'b1, 5'(16 + (i % 5)), 32'hB000_0000 + 32'(i));
        idle("lsu_fill_drain", 12);

        // Asynchronous reset with entries queued and a strobe in flight.
        for (int i = 0; i < 4; i++)
            cycle("pre_rst", 1'b1, 5'(1 + i), 32'hC000_0000 + 32'(i),
                  1'b1, 5'(9 + i), 32'hD000_0000 + 32'(i));
        check("queued_before_rst", 64'(alu_q.size() + lsu_q.size() >= 3), 64'd1);
        check("strobe_before_rst", 64'(write_back_output), 64'(exp_wb));
        alu_valid_input = 1'b0;
        lsu_valid_input = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_async");
        @(negedge clk);
        rst = 1'b1;
        idle("after_rst", 6);

        // Random traffic in phases of differing density.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int pct;
                pct = (ph == 0) ? 20 : (ph == 1) ? 50 : (ph == 2) ? 90 : 70;
                cycle("rand",
                      $urandom_range(99, 0) < pct, 5'($urandom_range(7, 0)), $urandom,
                      $urandom_range(99, 0) < pct, 5'($urandom_range(7, 0)), $urandom);
            end
        end
        idle("final_drain", 12);
        check_outputs("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
